// File: rtl/branch_predict_flush_if.sv
// ----------------------------------------------------------------------------
// branch_predict_flush_if
// Purpose : groups the ID-stage branch, EX-stage flag and resolve/statistics
//           signals of branch_predict_flush into one bundle.
// Params  : DATA_W - width of the PC and of the statistics counters.
// Modports: master - pipeline side (drives ID/flag/stall, observes results)
//           slave  - predictor side (branch_predict_flush)
// ----------------------------------------------------------------------------
interface branch_predict_flush_if #(
    parameter int DATA_W = 16
);
    logic              id_valid;
    logic [15:0]       id_instruction;
    logic [DATA_W-1:0] id_pc;
    logic              stall;
    logic              flag_we;
    logic              flag_z;
    logic              flag_v;
    logic              flag_n;
    logic              pred_taken;
    logic              flush;
    logic              actual_taken;
    logic              resolve_valid;
    logic [DATA_W-1:0] branch_cnt;
    logic [DATA_W-1:0] mispredict_cnt;

    modport master (
        output id_valid, id_instruction, id_pc, stall,
        output flag_we, flag_z, flag_v, flag_n,
        input  pred_taken, flush, actual_taken, resolve_valid,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  id_valid, id_instruction, id_pc, stall,
        input  flag_we, flag_z, flag_v, flag_n,
        output pred_taken, flush, actual_taken, resolve_valid,
        output branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_flush.sv
// ----------------------------------------------------------------------------
// branch_predict_flush
// Purpose : 2-bit saturating-counter branch predictor with a single resolve
//           stage. Predicts the ID-stage branch combinationally, resolves it
//           one unstalled cycle later against the Z/V/N flags (with bypass of
//           a same-cycle flag write) and raises a one-cycle flush on
//           mispredict. A flush also kills whatever branch sits in ID.
// Params  : DATA_W    - PC / statistics counter width (>= 8, > log2(PHT_DEPTH))
//           PHT_DEPTH - pattern-history entries, power of two, 2..256
// Ports   : clk   - sole clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - branch_predict_flush_if.slave:
//                   in : id_valid, id_instruction, id_pc, stall,
//                        flag_we, flag_z, flag_v, flag_n
//                   out: pred_taken, flush, actual_taken, resolve_valid,
//                        branch_cnt, mispredict_cnt
// Config  : BRANCH_STATS_EN - when defined, branch_cnt / mispredict_cnt count
//           resolved branches and flushes (saturating); otherwise both are 0.
// ----------------------------------------------------------------------------
module branch_predict_flush #(
    parameter int DATA_W    = 16,
    parameter int PHT_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_predict_flush_if.slave   bus
);
    localparam int IDX_W = $clog2(PHT_DEPTH);

    localparam logic [3:0] OP_BR_A   = 4'b1100;
    localparam logic [3:0] OP_BR_B   = 4'b1101;
    localparam logic [2:0] COND_AL   = 3'b111;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_ST    = 2'b11;

    // ID-stage decode and prediction
    logic [3:0]       id_op;
    logic [2:0]       id_cond;
    logic [IDX_W-1:0] id_idx;
    logic             id_is_br;
    logic             id_pred;

    // Resolve register
    logic             res_vld_q,  res_vld_d;
    logic [2:0]       res_cond_q, res_cond_d;
    logic [IDX_W-1:0] res_idx_q,  res_idx_d;
    logic             res_pred_q, res_pred_d;

    // Flag register
    logic             flag_z_q, flag_v_q, flag_n_q;

    // Pattern history table
    logic [1:0]       pht_q [PHT_DEPTH];

    // Resolution
    logic             ev_z, ev_v, ev_n;
    logic             cond_true;
    logic             resolve_valid;
    logic             actual_taken;
    logic             flush;
    logic             pht_upd;

    logic             unused_bits;

    assign id_op   = bus.id_instruction[15:12];
    assign id_cond = bus.id_instruction[11:9];
    // PCs are halfword aligned, so bit 0 carries no history information
    assign id_idx  = bus.id_pc[IDX_W:1];

    assign id_is_br = bus.id_valid && ((id_op == OP_BR_A) || (id_op == OP_BR_B));

    // Reads the registered table, so a same-cycle update to this index is
    // naturally invisible until the next cycle
    assign id_pred = id_is_br && ((id_cond == COND_AL) || pht_q[id_idx][1]);

    assign unused_bits = ^{bus.id_instruction[8:0], bus.id_pc[0],
                           bus.id_pc[DATA_W-1:IDX_W+1]};

    // Flag bypass: a flag write in the resolve cycle is the one the branch sees
    assign ev_z = bus.flag_we ? bus.flag_z : flag_z_q;
    assign ev_v = bus.flag_we ? bus.flag_v : flag_v_q;
    assign ev_n = bus.flag_we ? bus.flag_n : flag_n_q;

    always_comb begin
        cond_true = 1'b0;
        unique case (res_cond_q)
            3'b000:  cond_true = !ev_z;
            3'b001:  cond_true = ev_z;
            3'b010:  cond_true = !ev_z && !ev_n;
            3'b011:  cond_true = ev_n;
            3'b100:  cond_true = ev_z || !ev_n;
            3'b101:  cond_true = ev_n || ev_z;
            3'b110:  cond_true = ev_v;
            3'b111:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign resolve_valid = res_vld_q && !bus.stall;
    assign actual_taken  = resolve_valid && cond_true;
    assign flush         = resolve_valid && (actual_taken != res_pred_q);
    assign pht_upd       = resolve_valid && (res_cond_q != COND_AL);

    // Resolve-stage next state: hold on stall, else capture an unkilled branch
    always_comb begin
        res_vld_d  = res_vld_q;
        res_cond_d = res_cond_q;
        res_idx_d  = res_idx_q;
        res_pred_d = res_pred_q;
        if (!bus.stall) begin
            res_vld_d = id_is_br && !flush;
            if (id_is_br && !flush) begin
                res_cond_d = id_cond;
                res_idx_d  = id_idx;
                res_pred_d = id_pred;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld_q  <= 1'b0;
            res_cond_q <= 3'b000;
            res_idx_q  <= '0;
            res_pred_q <= 1'b0;
        end else begin
            res_vld_q  <= res_vld_d;
            res_cond_q <= res_cond_d;
            res_idx_q  <= res_idx_d;
            res_pred_q <= res_pred_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (bus.flag_we) begin
            flag_z_q <= bus.flag_z;
            flag_v_q <= bus.flag_v;
            flag_n_q <= bus.flag_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CTR_WNT;
            end
        end else if (pht_upd) begin
            if (actual_taken) begin
                if (pht_q[res_idx_q] != CTR_ST) begin
                    pht_q[res_idx_q] <= pht_q[res_idx_q] + 2'b01;
                end
            end else begin
                if (pht_q[res_idx_q] != CTR_SNT) begin
                    pht_q[res_idx_q] <= pht_q[res_idx_q] - 2'b01;
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [DATA_W-1:0] branch_cnt_q;
    logic [DATA_W-1:0] mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (resolve_valid && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (flush && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
`else
    assign bus.branch_cnt     = '0;
    assign bus.mispredict_cnt = '0;
`endif

    assign bus.pred_taken    = id_pred;
    assign bus.flush         = flush;
    assign bus.actual_taken  = actual_taken;
    assign bus.resolve_valid = resolve_valid;

endmodule

// File: doc/branch_predict_flush.md
BRANCH_PREDICT_FLUSH -- requirements
Module: branch_predict_flush

Interface
REQ-001 Parameter DATA_W, default 16, width of PC and of statistics counters (min 8).
REQ-002 Parameter PHT_DEPTH, default 16, number of pattern-history entries (power of 2, 2..256); IDX_W = log2(PHT_DEPTH).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 id_valid  input  1  ID-stage instruction valid.
REQ-006 id_instruction  input  16  ID-stage instruction; opcode [15:12], condition [11:9].
REQ-007 id_pc  input  DATA_W  byte address of ID-stage instruction.
REQ-008 stall  input  1  pipeline stall; holds the resolve stage.
REQ-009 flag_we, flag_z, flag_v, flag_n  input  1 each  EX-stage flag update strobe and new Z/V/N values.
REQ-010 pred_taken  output  1  combinational prediction for ID-stage branch.
REQ-011 flush  output  1  one-cycle mispredict flush pulse.
REQ-012 actual_taken  output  1  resolved direction, valid with resolve_valid.
REQ-013 resolve_valid  output  1  a branch resolved this cycle.
REQ-014 branch_cnt, mispredict_cnt  output  DATA_W each  statistics counters (see Configuration).

Function
REQ-015 A branch is id_valid with opcode 4'b1100 or 4'b1101; any other opcode SHALL give pred_taken=0 and no capture.
REQ-016 pred_taken SHALL be 1 for condition 3'b111; otherwise PHT[id_pc[IDX_W:1]][1].
REQ-017 PHT entries SHALL be 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 On a clock with a branch in ID, !stall and !flush, the resolve register SHALL capture condition, PHT index, pred_taken; otherwise (!stall) it SHALL load invalid; with stall it SHALL hold.
REQ-019 The module SHALL keep a Z/V/N flag register, written when flag_we=1.
REQ-020 Resolution SHALL use flag_z/v/n directly when flag_we=1 that cycle (bypass), else the flag register.
REQ-021 Condition truth: 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|!N; 101 N|Z; 110 V; 111 1.
REQ-022 resolve_valid SHALL be 1 when the resolve register is valid and stall=0; actual_taken SHALL then equal the evaluated condition, else 0.
REQ-023 flush SHALL equal resolve_valid & (actual_taken != captured pred_taken); latency ID->flush exactly 1 unstalled cycle.
REQ-024 On resolve_valid for condition != 111, the indexed PHT entry SHALL increment (taken) or decrement (not taken), saturating at 11/00.
REQ-025 PHT lookup in the same cycle as an update to the same index SHALL return the pre-update value.
REQ-026 A flush SHALL kill the branch in ID that cycle (REQ-018), so back-to-back branches never both flush.

Reset
REQ-027 rst_n=0 SHALL immediately clear: resolve register invalid, flags 0, all PHT entries to 01, counters 0; flush, resolve_valid, actual_taken 0.
REQ-028 Reset mid-resolution SHALL drop the pending branch with no flush and no PHT update.

Configuration
REQ-029 Macro BRANCH_STATS_EN defined: branch_cnt +1 per resolve_valid, mispredict_cnt +1 per flush, both saturating at all-ones.
REQ-030 BRANCH_STATS_EN undefined: both counters SHALL be absent and the outputs tied to 0.

Verification
REQ-031 After reset, branch cond 001, pc 0x0004, flags Z=1 via flag_we same cycle as resolve -> pred_taken=0, next cycle actual_taken=1, flush=1, PHT[2]=10.
REQ-032 Same branch resolved taken 3 more times -> PHT[2] saturates at 11, no flush after first, mispredict_cnt=1, branch_cnt=4 (stats enabled).
REQ-033 Unconditional (cond 111) at pc 0x0010 -> pred_taken=1, flush=0, PHT[8] stays 01.
REQ-034 Branch captured, stall=1 for 3 cycles -> resolve_valid=0 and flush=0 during stall; resolves on first unstalled cycle.
REQ-035 Two consecutive mispredicting branches -> flush on first only; second never resolves; branch_cnt +1.
REQ-036 rst_n pulsed low while a branch pending -> no flush, counters 0, PHT entry reads 01.
